// File: rtl/contador_pkg.sv
// rtl/contador_pkg.sv - shared constants, action encoding and parameter check for counter variants
package contador_pkg;

  localparam logic CONTA_CIMA  = 1'b1;
  localparam logic CONTA_BAIXO = 1'b0;

  typedef enum logic [1:0] {
    ACAO_HOLD   = 2'd0,
    ACAO_LOAD   = 2'd1,
    ACAO_REJECT = 2'd2,
    ACAO_COUNT  = 2'd3
  } acao_e;

  // Legal when 2 <= modulo <= 2**width; shared by every counter flavour.
  function automatic bit modulo_legal(input int width, input int modulo);
    return (width >= 1) && (width <= 31) && (modulo >= 2) &&
           (longint'(modulo) <= (longint'(1) << width));
  endfunction

endpackage

// File: rtl/contador_mod_n_if.sv
// rtl/contador_mod_n_if.sv - control/status bundle of one counter stage
interface contador_mod_n_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             carry_in;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             carry_out;
  logic             load_err;

  modport master (
    output enable, carry_in, up_down, load, load_value,
    input  count, tc, carry_out, load_err
  );

  modport slave (
    input  enable, carry_in, up_down, load, load_value,
    output count, tc, carry_out, load_err
  );
endinterface

// File: rtl/contador_mod_n.sv
// rtl/contador_mod_n.sv - cascadable modulo-N up/down counter with checked parallel load
module contador_mod_n
  import contador_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 6
) (
  input logic              clk,
  input logic              clear,
  contador_mod_n_if.slave  bus
);

  generate
    if (!modulo_legal(WIDTH, MODULO)) begin : g_bad_modulo
      $error("contador_mod_n: MODULO out of range for WIDTH");
    end
  endgenerate

  // MODULO == 2**WIDTH makes MAX_VAL all-ones, so wrap falls out of WIDTH-bit overflow.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  acao_e            acao;
  logic             at_max;
  logic             at_zero;
  logic             step;
  logic             wrap;
  logic [WIDTH-1:0] next_count;

  always_comb begin
    at_max  = (bus.count == MAX_VAL);
    at_zero = (bus.count == ZERO);
    step    = bus.enable & bus.carry_in;
    wrap    = (bus.up_down == CONTA_CIMA) ? at_max : at_zero;

    if (bus.up_down == CONTA_CIMA) begin
      next_count = at_max ? ZERO : bus.count + ONE;
    end else begin
      next_count = at_zero ? MAX_VAL : bus.count - ONE;
    end

    acao = ACAO_HOLD;
    if (bus.load) begin
      acao = (bus.load_value <= MAX_VAL) ? ACAO_LOAD : ACAO_REJECT;
    end else if (step) begin
      acao = ACAO_COUNT;
    end

    // Combinational so the next stage advances on the very edge this one wraps.
    bus.tc = ~clear & step & ~bus.load & wrap;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      bus.count     <= ZERO;
      bus.carry_out <= 1'b0;
      bus.load_err  <= 1'b0;
    end else begin
      case (acao)
        ACAO_LOAD: begin
          bus.count     <= bus.load_value;
          bus.carry_out <= 1'b0;
          bus.load_err  <= 1'b0;
        end
        ACAO_REJECT: begin
          bus.carry_out <= 1'b0;
          bus.load_err  <= 1'b1;
        end
        ACAO_COUNT: begin
          bus.count     <= next_count;
          bus.carry_out <= wrap;
          bus.load_err  <= 1'b0;
        end
        default: begin
          bus.carry_out <= 1'b0;
          bus.load_err  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/contador_mod_n.md
Name: contador_mod_n

Overview:
Parametrised, cascadable modulo-N counter. Successor of the fixed 0..5 counter.
- Adds configurable width and modulus, up/down counting, count enable, carry-in for cascading, and synchronous parallel load with range check.
- Registered terminal-event pulse for observers; combinational terminal-count output for chaining stages (e.g. seconds/minutes/hours clock chains built from 0-5 and 0-9 digits).

Parameters:
- WIDTH, 4: bit width of count and load_value.
- MODULO, 6: number of states; count sequence is 0..MODULO-1. Legal range 2 <= MODULO <= 2**WIDTH; anything else is an elaboration error.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- clear  input  1  synchronous, active-high reset; sampled on rising clk only.
- enable  input  1  count enable.
- carry_in  input  1  cascade input; counting requires enable=1 and carry_in=1. Tie to 1 on the lowest stage.
- up_down  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous parallel load request.
- load_value  input  WIDTH  value to load.
- count  output  WIDTH  registered current count.
- tc  output  1  combinational terminal count, for chaining into next stage's carry_in.
- carry_out  output  1  registered one-cycle pulse marking a wrap.
- load_err  output  1  registered one-cycle pulse marking a rejected load.

Behaviour:
- Reset:
  - clear=1 at a rising edge sets count=0, carry_out=0, load_err=0, overriding all other inputs.
  - Reset mid-count discards the count; no carry_out is produced on that edge.
- Priority at each rising edge: clear > load > count > hold.
- Load:
  - load=1 and load_value < MODULO: count <= load_value; carry_out <= 0; load_err <= 0.
  - load=1 and load_value >= MODULO: count unchanged; load_err <= 1; carry_out <= 0.
  - Load wins over counting on the same edge; enable and carry_in are ignored.
- Count step (load=0, enable=1, carry_in=1):
  - Up: count == MODULO-1 -> count <= 0, carry_out <= 1; otherwise count <= count+1, carry_out <= 0.
  - Down: count == 0 -> count <= MODULO-1, carry_out <= 1; otherwise count <= count-1, carry_out <= 0.
- Hold (no clear, no load, and enable=0 or carry_in=0): count unchanged; carry_out <= 0; load_err <= 0.
- Pulse outputs: carry_out and load_err are high for exactly one cycle after the triggering edge, never sticky.
- tc:
  - tc = enable & carry_in & ~load & (up_down ? count==MODULO-1 : count==0).
  - tc is forced to 0 while clear=1.
  - Purely combinational from inputs and count, no latency.
  - Cascaded stage N+1 must advance on the same edge on which stage N wraps.
- Direction change: up_down may change on any cycle; it takes effect at the next edge with no lost or extra step.
- Arithmetic: all compares and increments are done at WIDTH bits. When MODULO == 2**WIDTH, wrap occurs through natural overflow, and the compare must still yield identical results.
- Count never holds a value >= MODULO after reset.

Decomposition:
- Shared package contador_pkg:
  - Constants CONTA_CIMA=1'b1 and CONTA_BAIXO=1'b0 for up_down.
  - Parameter-legality check helper, reused by later counter variants.
- No sub-module: the block is a single leaf.
- Multi-digit chains are built in a separate future wrapper, contador_cascata, that instantiates contador_mod_n per digit.

Test Plan:
- Defaults (WIDTH=4, MODULO=6): clear for 1 cycle, then enable=carry_in=up_down=1 for 8 cycles -> count 1,2,3,4,5,0,1,2; carry_out high only in the cycle count shows 0 after 5.
- Down count: load_value=2 with load=1, then up_down=0 for 4 cycles -> count 2,1,0,5,4; tc=1 while count=0 with enable=1; carry_out pulse when count becomes 5.
- Load range check: load_value=7 with load=1 while count=3 -> count stays 3, load_err=1 for one cycle. load_value=5 -> count=5, load_err=0. load=1 with enable=1 on the same edge -> loaded value wins.
- Clear priority: at count=4 assert clear, load=1 and enable=1 together -> next count=0, carry_out=0, load_err=0, and tc=0 during clear. Clear asserted mid-cycle without a clock edge -> count unchanged until the edge.
- Cascade: stage A (MODULO=10) with its tc driving stage B (MODULO=6) carry_in, both enabled, run 65 cycles from 0 -> B:A reads 0:0..5:9, then 0:0, then 0:1 at cycle 61. B increments exactly on the edges where A wraps 9->0.
- Full-range modulus (WIDTH=3, MODULO=8): count up 9 cycles from 0 -> 1..7,0,1; carry_out on the 7->0 wrap. Down from 0 -> 7.
